// File: rtl/var_delay_line_if.sv
// Handshake and status bundle for var_delay_line: stream in, tapped stream out,
// delay programming and occupancy.
interface var_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DLY_W = 5
);
  logic             en;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic [DLY_W-1:0] dly_sel;
  logic             dly_load;
  logic             flush;
  logic             dout_valid;
  logic [WIDTH-1:0] dout;
  logic [DLY_W-1:0] cur_dly;
  logic             dly_clamped;
  logic [DLY_W-1:0] occ;

  modport master (
    output en, din_valid, din, dly_sel, dly_load, flush,
    input  dout_valid, dout, cur_dly, dly_clamped, occ
  );

  modport slave (
    input  en, din_valid, din, dly_sel, dly_load, flush,
    output dout_valid, dout, cur_dly, dly_clamped, occ
  );
endinterface

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line: MAX_STAGE data/valid stages, tap at cur_dly-1,
// with stall, flush, delay reload (which empties the line) and occupancy count.
module var_delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_STAGE = 16,
  parameter int DEF_DLY   = 4
) (
  input  logic         clk,
  input  logic         rst,
  var_delay_line_if.slave bus
);
  localparam int DLY_W = $clog2(MAX_STAGE + 1);

  logic [WIDTH-1:0]     data_p0 [MAX_STAGE];
  logic [MAX_STAGE-1:0] vld_p0;
  logic [DLY_W-1:0]     cur_dly_q;
  logic                 dly_clamped_q;

  logic                 dout_valid_c;
  logic [WIDTH-1:0]     dout_c;
  logic [DLY_W-1:0]     occ_c;

  function automatic logic sel_out_of_range(input logic [DLY_W-1:0] sel);
    return (sel == '0) || (int'(sel) > MAX_STAGE);
  endfunction

  function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] sel);
    if (sel == '0)
      return DLY_W'(1);
    if (int'(sel) > MAX_STAGE)
      return DLY_W'(MAX_STAGE);
    return sel;
  endfunction

  // Stage register: rst > dly_load > flush > en; a load or flush drops din on its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0        <= '0;
      for (int i = 0; i < MAX_STAGE; i++)
        data_p0[i] <= '0;
      cur_dly_q     <= DLY_W'(DEF_DLY);
      dly_clamped_q <= 1'b0;
    end else if (bus.dly_load) begin
      cur_dly_q     <= clamp_dly(bus.dly_sel);
      dly_clamped_q <= sel_out_of_range(bus.dly_sel);
      vld_p0        <= '0;
    end else if (bus.flush) begin
      vld_p0 <= '0;
    end else if (bus.en) begin
      data_p0[0] <= bus.din;
      vld_p0[0]  <= bus.din_valid;
      for (int i = 1; i < MAX_STAGE; i++) begin
        data_p0[i] <= data_p0[i-1];
        vld_p0[i]  <= vld_p0[i-1];
      end
    end
  end

  // Output tap and occupancy, combinational from the stage registers.
  always_comb begin
    dout_valid_c = 1'b0;
    dout_c       = '0;
    occ_c        = '0;
    for (int i = 0; i < MAX_STAGE; i++) begin
      if (DLY_W'(i + 1) == cur_dly_q) begin
        dout_valid_c = vld_p0[i];
        dout_c       = vld_p0[i] ? data_p0[i] : '0;
      end
      if ((DLY_W'(i) < cur_dly_q) && vld_p0[i])
        occ_c = occ_c + DLY_W'(1);
    end
  end

  assign bus.dout_valid  = dout_valid_c;
  assign bus.dout        = dout_c;
  assign bus.cur_dly     = cur_dly_q;
  assign bus.dly_clamped = dly_clamped_q;
  assign bus.occ         = occ_c;
endmodule

// File: tb/tb_var_delay_line.sv
// Directed vector bench for var_delay_line (WIDTH=8, MAX_STAGE=16, DEF_DLY=4).
module tb_var_delay_line;
  localparam int WIDTH     = 8;
  localparam int MAX_STAGE = 16;
  localparam int DEF_DLY   = 4;
  localparam int DLY_W     = $clog2(MAX_STAGE + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  var_delay_line_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) bus ();

  var_delay_line #(.WIDTH(WIDTH), .MAX_STAGE(MAX_STAGE), .DEF_DLY(DEF_DLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic             rst;
    logic             en;
    logic             dv;
    logic [WIDTH-1:0] din;
    logic [DLY_W-1:0] sel;
    logic             load;
    logic             flush;
    logic             e_dv;
    logic [WIDTH-1:0] e_dout;
    logic [DLY_W-1:0] e_cur;
    logic             e_clp;
    logic [DLY_W-1:0] e_occ;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic en, input logic dv,
                              input logic [WIDTH-1:0] din, input logic [DLY_W-1:0] sel,
                              input logic load, input logic flush,
                              input logic e_dv, input logic [WIDTH-1:0] e_dout,
                              input logic [DLY_W-1:0] e_cur, input logic e_clp,
                              input logic [DLY_W-1:0] e_occ);
    vec_t v;
    v.rst = r; v.en = en; v.dv = dv; v.din = din; v.sel = sel;
    v.load = load; v.flush = flush;
    v.e_dv = e_dv; v.e_dout = e_dout; v.e_cur = e_cur; v.e_clp = e_clp; v.e_occ = e_occ;
    return v;
  endfunction

  // Drive on the falling edge, clock once, sample 1 ns after the rising edge.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    rst          = v.rst;
    bus.en       = v.en;
    bus.din_valid = v.dv;
    bus.din      = v.din;
    bus.dly_sel  = v.sel;
    bus.dly_load = v.load;
    bus.flush    = v.flush;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.dout_valid !== v.e_dv || bus.dout !== v.e_dout || bus.cur_dly !== v.e_cur ||
        bus.dly_clamped !== v.e_clp || bus.occ !== v.e_occ) begin
      n_bad++;
      $display("FAIL %s: got dv=%b dout=%h cur=%0d clp=%b occ=%0d, want dv=%b dout=%h cur=%0d clp=%b occ=%0d",
               nm, bus.dout_valid, bus.dout, bus.cur_dly, bus.dly_clamped, bus.occ,
               v.e_dv, v.e_dout, v.e_cur, v.e_clp, v.e_occ);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.din_valid = 1'b0; bus.din = '0;
    bus.dly_sel = '0; bus.dly_load = 1'b0; bus.flush = 1'b0;

    // Reset, then ramp at the default delay of 4; dly_sel=9 without load is ignored.
    tbl.push_back(mk(1, 0, 0, 8'h00, 5'd0, 0, 0,  0, 8'h00, 5'd4, 0, 5'd0));
    tbl.push_back(mk(0, 1, 1, 8'h01, 5'd9, 0, 0,  0, 8'h00, 5'd4, 0, 5'd1));
    tbl.push_back(mk(0, 1, 1, 8'h02, 5'd9, 0, 0,  0, 8'h00, 5'd4, 0, 5'd2));
    tbl.push_back(mk(0, 1, 1, 8'h03, 5'd9, 0, 0,  0, 8'h00, 5'd4, 0, 5'd3));
    tbl.push_back(mk(0, 1, 1, 8'h04, 5'd9, 0, 0,  1, 8'h01, 5'd4, 0, 5'd4));
    tbl.push_back(mk(0, 1, 1, 8'h05, 5'd9, 0, 0,  1, 8'h02, 5'd4, 0, 5'd4));
    tbl.push_back(mk(0, 1, 1, 8'h06, 5'd9, 0, 0,  1, 8'h03, 5'd4, 0, 5'd4));
    // Three-cycle stall: output and occupancy frozen.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 1, 8'h07, 5'd9, 0, 0,  1, 8'h03, 5'd4, 0, 5'd4));
    tbl.push_back(mk(0, 1, 1, 8'h07, 5'd9, 0, 0,  1, 8'h04, 5'd4, 0, 5'd4));
    tbl.push_back(mk(0, 1, 1, 8'h08, 5'd9, 0, 0,  1, 8'h05, 5'd4, 0, 5'd4));
    // dly_sel=0 clamps to 1; din on the load edge is dropped.
    tbl.push_back(mk(0, 1, 1, 8'h09, 5'd0, 1, 0,  0, 8'h00, 5'd1, 1, 5'd0));
    tbl.push_back(mk(0, 1, 1, 8'h0A, 5'd9, 0, 0,  1, 8'h0A, 5'd1, 1, 5'd1));
    // dly_sel=20 clamps to 16; first item emerges after 16 enabled cycles.
    tbl.push_back(mk(0, 1, 1, 8'h0B, 5'd20, 1, 0, 0, 8'h00, 5'd16, 1, 5'd0));
    for (int j = 1; j <= 16; j++)
      tbl.push_back(mk(0, 1, 1, 8'(8'h0F + j), 5'd9, 0, 0,
                       (j == 16), (j == 16) ? 8'h10 : 8'h00, 5'd16, 1, 5'(j)));
    // dly_sel=7 in range.
    tbl.push_back(mk(0, 1, 1, 8'h1F, 5'd7, 1, 0,  0, 8'h00, 5'd7, 0, 5'd0));
    for (int j = 1; j <= 7; j++)
      tbl.push_back(mk(0, 1, 1, 8'(8'h1F + j), 5'd9, 0, 0,
                       (j == 7), (j == 7) ? 8'h20 : 8'h00, 5'd7, 0, 5'(j)));

    foreach (tbl[k])
      apply(tbl[k], $sformatf("tbl[%0d]", k));

    // Fill at delay 4, then flush together with a valid 0xAA which must be dropped.
    apply(mk(0, 1, 1, 8'h2F, 5'd4, 1, 0, 0, 8'h00, 5'd4, 0, 5'd0), "load4");
    apply(mk(0, 1, 1, 8'h30, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd1), "fill1");
    apply(mk(0, 1, 1, 8'h31, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd2), "fill2");
    apply(mk(0, 1, 1, 8'h32, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd3), "fill3");
    apply(mk(0, 1, 1, 8'h33, 5'd0, 0, 0, 1, 8'h30, 5'd4, 0, 5'd4), "fill4");
    apply(mk(0, 1, 1, 8'hAA, 5'd0, 0, 1, 0, 8'h00, 5'd4, 0, 5'd0), "flush");
    for (int j = 0; j < 5; j++)
      apply(mk(0, 1, 0, 8'h00, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd0), $sformatf("post_flush%0d", j));

    // Alternating valid at delay 3; bubbles carry X data that must not reach dout.
    apply(mk(0, 1, 0, 8'h00, 5'd3, 1, 0, 0, 8'h00, 5'd3, 0, 5'd0), "load3");
    apply(mk(0, 1, 1, 8'h41, 5'd0, 0, 0, 0, 8'h00, 5'd3, 0, 5'd1), "alt1");
    apply(mk(0, 1, 0, 8'hxx, 5'd0, 0, 0, 0, 8'h00, 5'd3, 0, 5'd1), "alt2");
    apply(mk(0, 1, 1, 8'h43, 5'd0, 0, 0, 1, 8'h41, 5'd3, 0, 5'd2), "alt3");
    apply(mk(0, 1, 0, 8'hxx, 5'd0, 0, 0, 0, 8'h00, 5'd3, 0, 5'd1), "alt4");
    apply(mk(0, 1, 1, 8'h45, 5'd0, 0, 0, 1, 8'h43, 5'd3, 0, 5'd2), "alt5");
    apply(mk(0, 1, 0, 8'hxx, 5'd0, 0, 0, 0, 8'h00, 5'd3, 0, 5'd1), "alt6");
    apply(mk(0, 1, 0, 8'hxx, 5'd0, 0, 0, 1, 8'h45, 5'd3, 0, 5'd1), "alt7");

    // Reset mid-stream wins over a simultaneous dly_load; delay returns to DEF_DLY.
    apply(mk(0, 1, 1, 8'h4F, 5'd0, 1, 0, 0, 8'h00, 5'd1, 1, 5'd0), "load0");
    apply(mk(0, 1, 1, 8'h50, 5'd0, 0, 0, 1, 8'h50, 5'd1, 1, 5'd1), "pre_rst");
    apply(mk(1, 1, 1, 8'h51, 5'd9, 1, 0, 0, 8'h00, 5'd4, 0, 5'd0), "rst_load");
    apply(mk(0, 1, 1, 8'h60, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd1), "post_rst1");
    apply(mk(0, 1, 1, 8'h61, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd2), "post_rst2");
    apply(mk(0, 1, 1, 8'h62, 5'd0, 0, 0, 0, 8'h00, 5'd4, 0, 5'd3), "post_rst3");
    apply(mk(0, 1, 1, 8'h63, 5'd0, 0, 0, 1, 8'h60, 5'd4, 0, 5'd4), "post_rst4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
